// File: rtl/uart_ft245_ctrl_if.sv
// CPU byte port and FT245 chip pins of the UART sequencer.
// The slave modport is the controller; the master modport is the CPU plus chip side.
interface uart_ft245_ctrl_if;
  logic [7:0] cpu_wdata;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_rdata;
  logic       flag_di;
  logic       flag_do;
  logic       tx_ovf;
  logic [7:0] ft_d_out;
  logic       ft_d_oe;
  logic [7:0] ft_d_in;
  logic       _ft_txe;
  logic       _ft_rxf;
  logic       ft_wr;
  logic       _ft_rd;

  modport master (
    output cpu_wdata, cpu_wr, cpu_rd, ft_d_in, _ft_txe, _ft_rxf,
    input  cpu_rdata, flag_di, flag_do, tx_ovf, ft_d_out, ft_d_oe, ft_wr, _ft_rd
  );
  modport slave (
    input  cpu_wdata, cpu_wr, cpu_rd, ft_d_in, _ft_txe, _ft_rxf,
    output cpu_rdata, flag_di, flag_do, tx_ovf, ft_d_out, ft_d_oe, ft_wr, _ft_rd
  );
endinterface

// File: rtl/uart_ft245_ctrl.sv
// FT245 USB FIFO sequencer: buffered TX bytes, single-byte RX holding register,
// and TX/RX arbitration of the shared chip data bus.
module uart_ft245_ctrl #(
  parameter int TX_DEPTH       = 4,
  parameter int WR_CYCLES      = 2,
  parameter int RD_CYCLES      = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             _mr,
  uart_ft245_ctrl_if.slave bus
);
  localparam int AW   = $clog2(TX_DEPTH);
  localparam int MAXC = (WR_CYCLES > RD_CYCLES)
                        ? ((WR_CYCLES > RECOVER_CYCLES) ? WR_CYCLES : RECOVER_CYCLES)
                        : ((RD_CYCLES > RECOVER_CYCLES) ? RD_CYCLES : RECOVER_CYCLES);
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {IDLE, TX_SETUP, TX_STROBE, TX_HOLD, RX_STROBE, RECOVER} state_t;
  typedef enum logic {SRV_TX, SRV_RX} srv_t;

  state_t        state, state_n;
  srv_t          last_srv, last_srv_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    txe_sync, rxf_sync;
  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop_fifo, rx_cap, load_d;
  logic          tx_elig, rx_elig, rx_valid;
  logic [7:0]    rdata_q, dout_q;
  logic          wr_q, rd_q, oe_q, ovf_q;

  assign full    = (count == (AW+1)'(TX_DEPTH));
  assign empty   = (count == '0);
  assign push    = bus.cpu_wr && !full;
  assign tx_elig = !empty && !txe_sync[1];
  assign rx_elig = !rx_valid && !rxf_sync[1];

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state    <= IDLE;
      last_srv <= SRV_RX;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      last_srv <= last_srv_n;
      cnt      <= cnt_n;
    end
  end

  // One counter times every strobe and recovery phase; loaded with length-1 on entry.
  always_comb begin
    state_n    = state;
    last_srv_n = last_srv;
    cnt_n      = cnt;
    pop_fifo   = 1'b0;
    rx_cap     = 1'b0;
    load_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_elig && (!rx_elig || last_srv == SRV_RX)) begin
          state_n    = TX_SETUP;
          last_srv_n = SRV_TX;
          load_d     = 1'b1;
        end else if (rx_elig) begin
          state_n    = RX_STROBE;
          last_srv_n = SRV_RX;
          cnt_n      = CW'(RD_CYCLES - 1);
        end
      end
      TX_SETUP: begin
        state_n = TX_STROBE;
        cnt_n   = CW'(WR_CYCLES - 1);
      end
      TX_STROBE: begin
        if (cnt == '0) state_n = TX_HOLD;
        else           cnt_n   = cnt - 1'b1;
      end
      TX_HOLD: begin
        state_n  = RECOVER;
        cnt_n    = CW'(RECOVER_CYCLES - 1);
        pop_fifo = 1'b1;
      end
      RX_STROBE: begin
        if (cnt == '0) begin
          state_n = RECOVER;
          cnt_n   = CW'(RECOVER_CYCLES - 1);
          rx_cap  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Chip pins are registered from the next state so they never glitch on decode.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b1;
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      wr_q <= (state_n == TX_STROBE);
      rd_q <= (state_n != RX_STROBE);
      oe_q <= (state_n == TX_SETUP) || (state_n == TX_STROBE) || (state_n == TX_HOLD);
      if (load_d) dout_q <= mem[rptr];
    end
  end

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      txe_sync <= 2'b11;
      rxf_sync <= 2'b11;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
      rx_valid <= 1'b0;
      rdata_q  <= '0;
    end else begin
      txe_sync <= {txe_sync[0], bus._ft_txe};
      rxf_sync <= {rxf_sync[0], bus._ft_rxf};
      if (push)                   wptr  <= wptr + 1'b1;
      if (pop_fifo)               rptr  <= rptr + 1'b1;
      if (push != pop_fifo)       count <= push ? count + 1'b1 : count - 1'b1;
      if (bus.cpu_wr && full)     ovf_q <= 1'b1;
      if (rx_cap) begin
        rdata_q  <= bus.ft_d_in;
        rx_valid <= 1'b1;
      end else if (bus.cpu_rd && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.cpu_wdata;
  end

  assign bus.ft_wr     = wr_q;
  assign bus._ft_rd    = rd_q;
  assign bus.ft_d_oe   = oe_q;
  assign bus.ft_d_out  = dout_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.flag_di   = rx_valid;
  assign bus.flag_do   = !full;
  assign bus.tx_ovf    = ovf_q;
endmodule
